// File: rtl/uart_bus_bridge_pkg.sv
// uart_bus_bridge_pkg: command/response codes and FSM state encoding for the uart bus bridge
package uart_bus_bridge_pkg;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h3F;
   localparam logic [7:0] RSP_TMO = 8'h54;
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_REQ, S_BUS_RD, S_BUS_WR, S_RESP
   } state_e;
endpackage

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: host byte-stream command decoder acting as a second initiator on the peripheral bus
module uart_bus_bridge
   import uart_bus_bridge_pkg::*;
#(
   parameter int W       = 32,
   parameter int AW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          bus_req,
   input  logic          bus_gnt,
   output logic [AW-1:0] addr,
   output logic          ren,
   input  logic [W-1:0]  rdata,
   input  logic          rd_valid,
   output logic          wen,
   output logic [W-1:0]  wdata,
   output logic [3:0]    wmask,
   output logic          busy
);
   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [W-1:0]  wdata_q, wdata_d;
   logic [W-1:0]  resp_q, resp_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [7:0]    tmo_q, tmo_d;
   logic          wr_q, wr_d;
   // next-state: cnt_q counts data bytes while receiving and remaining tx bytes while responding
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      resp_d  = resp_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      wr_d    = wr_q;
      case (state_q)
         S_IDLE: if (rx_valid) begin
            if (rx_data == CMD_RD || rx_data == CMD_WR) begin
               wr_d    = rx_data == CMD_WR;
               state_d = S_ADDR_HI;
            end else begin
               resp_d  = W'(RSP_ERR);
               cnt_d   = 2'd0;
               state_d = S_RESP;
            end
         end
         S_ADDR_HI: if (rx_valid) begin
            addr_d  = {addr_q[AW-9:0], rx_data};
            state_d = S_ADDR_LO;
         end
         S_ADDR_LO: if (rx_valid) begin
            addr_d  = {addr_q[AW-9:0], rx_data};
            cnt_d   = 2'd0;
            state_d = wr_q ? S_DATA : S_REQ;
         end
         S_DATA: if (rx_valid) begin
            wdata_d = {rx_data, wdata_q[W-1:8]};
            cnt_d   = cnt_q + 2'd1;
            state_d = cnt_q == 2'd3 ? S_REQ : S_DATA;
         end
         S_REQ: if (bus_gnt) begin
            tmo_d   = 8'd0;
            state_d = wr_q ? S_BUS_WR : S_BUS_RD;
         end
         S_BUS_WR: begin
            resp_d  = W'(RSP_OK);
            cnt_d   = 2'd0;
            state_d = S_RESP;
         end
         S_BUS_RD: if (rd_valid) begin
            resp_d  = rdata;
            cnt_d   = 2'd3;
            state_d = S_RESP;
         end else if (tmo_q == 8'(TIMEOUT - 1)) begin
            resp_d  = W'(RSP_TMO);
            cnt_d   = 2'd0;
            state_d = S_RESP;
         end else begin
            tmo_d = tmo_q + 8'd1;
         end
         S_RESP: if (tx_ready) begin
            resp_d  = resp_q >> 8;
            cnt_d   = cnt_q - 2'd1;
            state_d = cnt_q == 2'd0 ? S_IDLE : S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state register; reset discards any partial command and any pending response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         resp_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         resp_q  <= resp_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         wr_q    <= wr_d;
      end
   end
   assign busy     = state_q != S_IDLE;
   assign bus_req  = state_q == S_REQ || state_q == S_BUS_RD || state_q == S_BUS_WR;
   assign ren      = state_q == S_BUS_RD;
   assign wen      = state_q == S_BUS_WR;
   assign wmask    = {4{wen}};
   assign addr     = addr_q;
   assign wdata    = wdata_q;
   assign tx_valid = state_q == S_RESP;
   assign tx_data  = tx_valid ? resp_q[7:0] : 8'h00;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: scoreboard bench for the uart bus bridge (tx bytes queued at stimulus, checked on accept)
module tb_uart_bus_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        bus_req;
   logic        bus_gnt = 1'b1;
   logic [15:0] addr;
   logic        ren;
   logic [31:0] rdata = 32'h0;
   logic        rd_valid = 1'b0;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        busy;

   logic [7:0]  sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          wen_cyc = 0;
   int          ren_cyc = 0;
   int          viol = 0;
   logic [15:0] w_addr, r_addr;
   logic [31:0] w_data;
   logic [3:0]  w_mask;
   bit          resp_en = 1'b1;
   int          rd_delay = 0;
   int          rd_cnt = 0;

   uart_bus_bridge dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .addr(addr), .ren(ren),
      .rdata(rdata), .rd_valid(rd_valid), .wen(wen), .wdata(wdata),
      .wmask(wmask), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // bus responder: raises rd_valid once ren has been high for rd_delay cycles
   always @(posedge clk) begin
      #1;
      if (ren && resp_en) begin
         rd_valid = rd_cnt == rd_delay;
         rd_cnt++;
      end else begin
         rd_valid = 1'b0;
         rd_cnt = 0;
      end
   end

   // bus and tx monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (wen) begin
         wen_cyc++;
         w_addr = addr;
         w_data = wdata;
         w_mask = wmask;
      end
      if (ren) begin
         ren_cyc++;
         r_addr = addr;
      end
      if (((ren || wen) && !bus_req) || (ren && wen)) viol++;
      if (!rst && tx_valid && tx_ready) begin
         if (sb.size() == 0) check_eq("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
         else check_eq("tx_byte", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (!busy && sb.size() == 0) break;
      end
      check_eq(tag, {31'h0, i < budget}, 32'h1);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_ctl"}, {23'h0, tx_valid, bus_req, ren, wen, busy, wmask}, 32'h0);
      check_eq({tag, "_addr"}, {16'h0, addr}, 32'h0);
      check_eq({tag, "_wdata"}, wdata, 32'h0);
      check_eq({tag, "_txd"}, {24'h0, tx_data}, 32'h0);
   endtask

   initial begin
      int bad;
      int k;
      logic [7:0] b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // write, grant tied high
      wen_cyc = 0;
      sb.push_back(8'h4B);
      send(8'h57); send(8'h40); send(8'h00);
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      wait_idle("wr_done", 50);
      check_eq("wr_pulses", wen_cyc, 1);
      check_eq("wr_addr", {16'h0, w_addr}, 32'h4000);
      check_eq("wr_data", w_data, 32'h0000_0001);
      check_eq("wr_mask", {28'h0, w_mask}, 32'hF);

      // read with completion 3 cycles after ren
      ren_cyc = 0;
      rd_delay = 3;
      rdata = 32'hDEAD_BEEF;
      push_word(32'hDEAD_BEEF);
      send(8'h52); send(8'h80); send(8'h10);
      wait_idle("rd_done", 50);
      check_eq("rd_ren_cycles", ren_cyc, 4);
      check_eq("rd_addr", {16'h0, r_addr}, 32'h8010);

      // grant stall on a write
      bus_gnt = 1'b0;
      wen_cyc = 0;
      sb.push_back(8'h4B);
      send(8'h57); send(8'h12); send(8'h34);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bus_req || ren || wen) bad++;
      end
      check_eq("stall_hold", bad, 0);
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(negedge clk);
      check_eq("stall_pre_wen", {31'h0, wen}, 32'h0);
      @(negedge clk);
      check_eq("stall_wen", {31'h0, wen}, 32'h1);
      wait_idle("stall_done", 50);
      check_eq("stall_pulses", wen_cyc, 1);
      check_eq("stall_data", w_data, 32'hDDCC_BBAA);
      check_eq("stall_addr", {16'h0, w_addr}, 32'h1234);

      // unknown command
      sb.push_back(8'h3F);
      send(8'h00);
      wait_idle("unk_done", 20);

      // read timeout
      resp_en = 1'b0;
      ren_cyc = 0;
      sb.push_back(8'h54);
      send(8'h52); send(8'h00); send(8'h00);
      wait_idle("tmo_done", 400);
      check_eq("tmo_ren_cycles", ren_cyc, 255);

      // rd_valid on the timeout cycle gives a normal response
      resp_en = 1'b1;
      rd_delay = 254;
      rdata = 32'h0BAD_C0DE;
      ren_cyc = 0;
      push_word(32'h0BAD_C0DE);
      send(8'h52); send(8'h00); send(8'h02);
      wait_idle("edge_done", 400);
      check_eq("edge_ren_cycles", ren_cyc, 255);

      // tx backpressure with a stray rx byte during the response
      tx_ready = 1'b0;
      rd_delay = 0;
      rdata = 32'h1122_3344;
      push_word(32'h1122_3344);
      send(8'h52); send(8'h00); send(8'h04);
      for (k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (tx_valid) break;
      end
      check_eq("bp_reach_resp", {31'h0, k < 50}, 32'h1);
      b0 = tx_data;
      check_eq("bp_first", {24'h0, b0}, 32'h44);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         rx_data = 8'h57;
         rx_valid = i == 2;
         if (!tx_valid || tx_data !== b0) bad++;
      end
      rx_valid = 1'b0;
      check_eq("bp_stable", bad, 0);
      tx_ready = 1'b1;
      wait_idle("bp_done", 50);
      repeat (3) @(posedge clk);
      #1;
      check_eq("bp_idle", {31'h0, busy}, 32'h0);

      // reset during BUS_RD
      resp_en = 1'b0;
      send(8'h52); send(8'h00); send(8'h08);
      for (k = 0; k < 20; k++) begin
         if (ren) break;
         @(posedge clk); #1;
      end
      check_eq("rst_rd_reach", {31'h0, ren}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("rst_rd");
      rst = 1'b0;

      // reset after two data bytes of a write
      send(8'h57); send(8'h00); send(8'h00); send(8'h11); send(8'h22);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("rst_wr");
      rst = 1'b0;

      // fresh read completes normally
      resp_en = 1'b1;
      rd_delay = 1;
      rdata = 32'hCAFE_F00D;
      ren_cyc = 0;
      push_word(32'hCAFE_F00D);
      send(8'h52); send(8'h00); send(8'h0C);
      wait_idle("post_rst_done", 50);
      check_eq("post_rst_addr", {16'h0, r_addr}, 32'h000C);
      check_eq("post_rst_ren_cycles", ren_cyc, 2);

      check_eq("bus_protocol", viol, 0);
      check_eq("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
